// File: rtl/batt_mon_pkg.sv
// Shared types and default constants for the battery monitor.
package batt_mon_pkg;

  localparam int unsigned ADC_W = 12;
  localparam int unsigned REP_W = 25;

  localparam int unsigned     AVG_SHIFT_DEF  = 3;
  localparam logic [ADC_W-1:0] LOW_THR_DEF    = 12'hC00;
  localparam logic [ADC_W-1:0] HYST_DEF       = 12'h040;
  localparam logic [REP_W-1:0] REPEAT_CYC_DEF = 25'd25000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CMP   = 2'd2
  } state_t;

  // Clear threshold is one bit wider so LOW_THR+HYST past the ADC range
  // yields a level no average can reach (flag then never clears).
  function automatic logic [ADC_W:0] clr_thr(input logic [ADC_W-1:0] low_thr,
                                             input logic [ADC_W-1:0] hyst);
    return {1'b0, low_thr} + {1'b0, hyst};
  endfunction

endpackage

// File: rtl/batt_mon_rpt_tmr.sv
// Loadable down-counter that pulses tc on reaching zero and reloads itself.
module rpt_tmr
  import batt_mon_pkg::*;
#(
  parameter int unsigned W = REP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  // Terminal count and next count; clear beats load beats counting.
  always_comb begin
    tc    = en & (cnt_q == '0);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (tc) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/batt_mon.sv
// Battery monitor: averages ADC samples, tracks low battery with hysteresis,
// and issues the single-cycle batt_low / fanfare triggers for the piezo driver.
// Build option: define BATT_LATCH_EN to make the low flag sticky until reset.
module batt_mon
  import batt_mon_pkg::*;
#(
  parameter int unsigned      AVG_SHIFT  = AVG_SHIFT_DEF,
  parameter logic [ADC_W-1:0] LOW_THR    = LOW_THR_DEF,
  parameter logic [ADC_W-1:0] HYST       = HYST_DEF,
  parameter logic [REP_W-1:0] REPEAT_CYC = REPEAT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADC_W-1:0] batt_smpl,
  input  logic             batt_vld,
  output logic             batt_rdy,
  input  logic             sol_cmplt,
  output logic             batt_low,
  output logic             fanfare,
  output logic             batt_lvl_low
);

  localparam int unsigned ACC_W = ADC_W + AVG_SHIFT;
`ifndef BATT_LATCH_EN
  localparam logic [ADC_W:0] CLR_THR = clr_thr(LOW_THR, HYST);
`endif

  state_t state_q, state_d;
  logic   accept, last_smpl, cmp_en;

  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [AVG_SHIFT-1:0] smpl_cnt_q, smpl_cnt_d;
  logic [ADC_W-1:0]     avg;
  logic                 flag_q, flag_d, rise, fall;

  logic sol_q, ff_req, bl_req, tmr_tc;
  logic pend_q, pend_d;
  logic batt_low_q, batt_low_d;
  logic fanfare_q, fanfare_d;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave ACCUM on the last sample of the window.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ACCUM;
      ACCUM:   if (accept && last_smpl) state_d = CMP;
      CMP:     state_d = ACCUM;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ready only while accumulating.
  always_comb begin
    batt_rdy  = (state_q == ACCUM);
    cmp_en    = (state_q == CMP);
    accept    = batt_vld & batt_rdy;
    last_smpl = (smpl_cnt_q == '1);
  end

  // Accumulator, sample count and low flag update.
  always_comb begin
    acc_d      = acc_q;
    smpl_cnt_d = smpl_cnt_q;
    flag_d     = flag_q;
    avg        = ADC_W'(acc_q >> AVG_SHIFT);
    if (cmp_en) begin
      acc_d      = '0;
      smpl_cnt_d = '0;
      if (avg < LOW_THR) begin
        flag_d = 1'b1;
      end
`ifndef BATT_LATCH_EN
      else if ({1'b0, avg} >= CLR_THR) begin
        flag_d = 1'b0;
      end
`endif
    end else if (accept) begin
      acc_d      = acc_q + ACC_W'(batt_smpl);
      smpl_cnt_d = smpl_cnt_q + AVG_SHIFT'(1);
    end
    rise = flag_d & ~flag_q;
    fall = flag_q & ~flag_d;
  end

  // Re-trigger timer runs only while the low flag is set.
  rpt_tmr #(.W(REP_W)) u_rpt_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (rise),
    .clr      (fall),
    .en       (flag_q),
    .load_val (REPEAT_CYC - REP_W'(1)),
    .tc       (tmr_tc)
  );

  // Trigger arbitration: fanfare wins, a displaced batt_low goes out next cycle.
  always_comb begin
    ff_req     = sol_cmplt & ~sol_q;
    bl_req     = (rise | tmr_tc | pend_q) & ~fall;
    fanfare_d  = ff_req;
    batt_low_d = bl_req & ~ff_req;
    pend_d     = bl_req & ff_req;
  end

  // Datapath and trigger registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      smpl_cnt_q <= '0;
      flag_q     <= 1'b0;
      sol_q      <= 1'b0;
      pend_q     <= 1'b0;
      batt_low_q <= 1'b0;
      fanfare_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      smpl_cnt_q <= smpl_cnt_d;
      flag_q     <= flag_d;
      sol_q      <= sol_cmplt;
      pend_q     <= pend_d;
      batt_low_q <= batt_low_d;
      fanfare_q  <= fanfare_d;
    end
  end

  assign batt_low     = batt_low_q;
  assign fanfare      = fanfare_q;
  assign batt_lvl_low = flag_q;

endmodule
